uart_frame_sched: RTL and testbench
===================================

Name: uart_frame_sched

Overview:
Frame scheduler between the frequency packer (64-bit packet plus one-cycle valid strobe) and the byte-wide UART transmitter. It snapshots each 64-bit packet and sequences it to the transmitter as an 11-byte frame: 2 header bytes, 8 payload bytes MSB-first, and 1 checksum byte. It owns the transmitter handshake, buffers one pending packet, and counts dropped packets.

Parameters:
HDR0, 8'hAA, first header byte
HDR1, 8'h55, second header byte
DROP_W, 16, width of the saturating drop counter

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous reset, active-low
pkt_data  in  64  packet: {freq1[31:0], freq2[31:0]}
pkt_en  in  1  one-cycle packet-valid strobe
tx_busy  in  1  transmitter busy; rises the cycle after tx_en and stays high until the byte is finished
tx_data  out  8  byte to transmit; stable while tx_en is high
tx_en  out  1  one-cycle transmit request
frame_busy  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse after the last byte completes
drop_cnt  out  DROP_W  count of overwritten pending packets, saturating

Behaviour:
- Reset (sys_rst_n low at a sys_clk edge) clears everything: state=IDLE, tx_data=0, tx_en=0, frame_busy=0, frame_done=0, drop_cnt=0, pending buffer empty, byte index=0, checksum=0.
- Reset mid-frame abandons the partial frame. tx_en is low from the next edge.
- All outputs are registered.
- States:
  - IDLE: on pkt_en, or with the pending buffer valid, load the frame shift register from pkt_data (or from pending, clearing it). Set byte_idx=0, checksum=0, frame_busy=1. Go to ISSUE.
  - ISSUE: wait while tx_busy=1. When tx_busy=0, register tx_data=byte(byte_idx) and tx_en=1. Go to GUARD.
  - GUARD: one cycle, covering the tx_busy rise latency. tx_en returns to 0. Go to WAIT.
  - WAIT: stay while tx_busy=1. On tx_busy=0:
    - if byte_idx=10, go to DONE;
    - otherwise increment byte_idx and go to ISSUE.
  - DONE: pulse frame_done=1 and clear frame_busy. If pending is valid, or pkt_en is high this cycle, start the next frame directly (same actions as in IDLE). Otherwise go to IDLE.
- Byte order by index:
  - idx 0 = HDR0, idx 1 = HDR1
  - idx 2..9 = payload bits [63:56] down to [7:0]
  - idx 10 = checksum
- Checksum: 8-bit modulo-256 sum of the 8 payload bytes only. Accumulated when each payload byte is issued.
- Latency: pkt_en sampled in IDLE with tx_busy=0 gives tx_en high 2 edges later. Back-to-back bytes are spaced by transmitter busy time + 2 cycles.
- Pending buffer: pkt_en while the state is not IDLE writes pkt_data to pending and sets it valid.
  - If pending is already valid, the newest packet overwrites it and drop_cnt increments, saturating at all-ones.
  - pkt_en in DONE with pending valid: the pending packet starts the frame; the new packet goes to pending, with no drop.
- The payload is frozen for the whole frame. pkt_data changing mid-frame has no effect.
- tx_en is never asserted while tx_busy=1 and is never high for 2 consecutive cycles.

Decomposition:
- Shared package holds:
  - FRAME_LEN=11;
  - header defaults 8'hAA/8'h55;
  - the state enum (IDLE, ISSUE, GUARD, WAIT, DONE);
  - byte-index constants IDX_PAY_FIRST=2, IDX_CHK=10.
- One sub-module is natural: frame_byte_sel, a combinational selector mapping byte_idx, the payload register and the checksum to the outgoing byte.

Test Plan:
1. Reset, then pkt_data=64'h0000_0064_0000_00C8 with pkt_en, transmitter model busy 20 cycles per byte -> bytes AA 55 00 00 00 64 00 00 00 C8 2C, one frame_done pulse, drop_cnt=0.
2. tx_busy held high when pkt_en arrives -> no tx_en until tx_busy falls; then tx_en high for exactly 1 cycle.
3. Three pkt_en during one frame (payloads P1, P2, P3) -> drop_cnt=1, and the next frame carries P3. Repeat until drop_cnt saturates at 16'hFFFF -> no wrap.
4. pkt_en coincident with DONE, pending empty -> the next frame starts with no IDLE cycle; frame_busy low for exactly 1 cycle.
5. sys_rst_n low during payload byte 5 -> tx_en=0, frame_busy=0, drop_cnt=0 after the edge. A new pkt_en then gives a complete fresh frame starting with AA.
6. Payload all 8'hFF -> checksum 8'hF8 (wrap-around).

Source files
------------

// File: rtl/uart_frame_sched_pkg.sv
// Shared constants and state encoding for the UART frame scheduler.
package uart_frame_sched_pkg;

  localparam int FRAME_LEN = 11;
  localparam int IDX_W     = 4;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  localparam logic [IDX_W-1:0] IDX_PAY_FIRST = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CHK       = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/frame_byte_sel.sv
// Maps the frame byte index onto header, payload (MSB-first) or checksum byte.
module frame_byte_sel
  import uart_frame_sched_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic [IDX_W-1:0] byte_idx,
  input  logic [63:0]      payload,
  input  logic [7:0]       checksum,
  output logic [7:0]       byte_out
);

  always_comb begin
    byte_out = 8'h00;
    case (byte_idx)
      4'd0:    byte_out = HDR0;
      4'd1:    byte_out = HDR1;
      4'd2:    byte_out = payload[63:56];
      4'd3:    byte_out = payload[55:48];
      4'd4:    byte_out = payload[47:40];
      4'd5:    byte_out = payload[39:32];
      4'd6:    byte_out = payload[31:24];
      4'd7:    byte_out = payload[23:16];
      4'd8:    byte_out = payload[15:8];
      4'd9:    byte_out = payload[7:0];
      IDX_CHK: byte_out = checksum;
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Sequences 64-bit packets into 11-byte UART frames with a one-deep pending buffer.
//   state | meaning
//   IDLE  | no frame; start on pkt_en or pending packet
//   ISSUE | wait for transmitter idle, then launch current byte
//   GUARD | cover the tx_busy rise latency after tx_en
//   WAIT  | wait for byte to finish; advance or finish frame
//   DONE  | frame_done pulse; optionally start next frame
module uart_frame_sched
  import uart_frame_sched_pkg::*;
#(
  parameter logic [7:0] HDR0   = HDR0_DEF,
  parameter logic [7:0] HDR1   = HDR1_DEF,
  parameter int         DROP_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [63:0]       pkt_data,
  input  logic              pkt_en,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t             state, state_nxt;
  logic [63:0]        payload, payload_nxt;
  logic [63:0]        pend_data, pend_data_nxt;
  logic               pend_vld, pend_vld_nxt;
  logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
  logic [7:0]         checksum, checksum_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_en_nxt;
  logic               frame_busy_nxt;
  logic               frame_done_nxt;
  logic [DROP_W-1:0]  drop_cnt_nxt;
  logic [7:0]         cur_byte;

  frame_byte_sel #(
    .HDR0 (HDR0),
    .HDR1 (HDR1)
  ) u_byte_sel (
    .byte_idx (byte_idx),
    .payload  (payload),
    .checksum (checksum),
    .byte_out (cur_byte)
  );

  always_comb begin
    state_nxt      = state;
    payload_nxt    = payload;
    pend_data_nxt  = pend_data;
    pend_vld_nxt   = pend_vld;
    byte_idx_nxt   = byte_idx;
    checksum_nxt   = checksum;
    tx_data_nxt    = tx_data;
    tx_en_nxt      = 1'b0;
    frame_busy_nxt = frame_busy;
    frame_done_nxt = 1'b0;
    drop_cnt_nxt   = drop_cnt;

    // Mid-frame packets park in pending; overwriting a valid one is a drop.
    if (pkt_en && (state != IDLE) && (state != DONE)) begin
      pend_data_nxt = pkt_data;
      pend_vld_nxt  = 1'b1;
      if (pend_vld && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt_nxt = drop_cnt + DROP_W'(1);
      end
    end

    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          frame_busy_nxt = 1'b0;
          state_nxt      = IDLE;
        end
        if (pkt_en || pend_vld) begin
          if (pend_vld) begin
            payload_nxt  = pend_data;
            pend_vld_nxt = pkt_en;
            if (pkt_en) begin
              pend_data_nxt = pkt_data;
            end
          end else begin
            payload_nxt = pkt_data;
          end
          byte_idx_nxt   = '0;
          checksum_nxt   = 8'h00;
          frame_busy_nxt = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_data_nxt = cur_byte;
          tx_en_nxt   = 1'b1;
          if ((byte_idx >= IDX_PAY_FIRST) && (byte_idx < IDX_CHK)) begin
            checksum_nxt = checksum + cur_byte;
          end
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (byte_idx == IDX_CHK) begin
            frame_done_nxt = 1'b1;
            frame_busy_nxt = 1'b0;
            state_nxt      = DONE;
          end else begin
            byte_idx_nxt = byte_idx + IDX_W'(1);
            state_nxt    = ISSUE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      payload    <= '0;
      pend_data  <= '0;
      pend_vld   <= 1'b0;
      byte_idx   <= '0;
      checksum   <= 8'h00;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      payload    <= payload_nxt;
      pend_data  <= pend_data_nxt;
      pend_vld   <= pend_vld_nxt;
      byte_idx   <= byte_idx_nxt;
      checksum   <= checksum_nxt;
      tx_data    <= tx_data_nxt;
      tx_en      <= tx_en_nxt;
      frame_busy <= frame_busy_nxt;
      frame_done <= frame_done_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench for uart_frame_sched with a simple busy-time transmitter model.
module tb_uart_frame_sched;

  localparam int BUSY_LEN = 20;
  localparam int WAIT_MAX = 3000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] pkt_data = '0;
  logic        pkt_en = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] drop_cnt;

  logic        hold_busy = 1'b0;
  logic        model_busy = 1'b0;
  int          busy_cnt = 0;
  logic        prev_tx_en = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  sb[$];
  int          bytes_seen = 0;
  int          done_seen = 0;

  logic [15:0] exp_drop = '0;
  logic        exp_pend = 1'b0;
  logic [63:0] exp_pend_data = '0;

  assign tx_busy = model_busy | hold_busy;

  always #5 sys_clk = ~sys_clk;

  uart_frame_sched dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pkt_data   (pkt_data),
    .pkt_en     (pkt_en),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] p);
    logic [7:0] sum;
    sum = 8'h00;
    sb.push_back(8'hAA);
    sb.push_back(8'h55);
    for (int i = 7; i >= 0; i--) begin
      sb.push_back(p[i*8 +: 8]);
      sum = sum + p[i*8 +: 8];
    end
    sb.push_back(sum);
  endtask

  // Transmitter model and byte monitor, sampled away from the active edge.
  always @(negedge sys_clk) begin
    logic busy_now;
    busy_now = tx_busy;
    if (frame_done) done_seen++;
    if (tx_en) begin
      bytes_seen++;
      check("tx_en_while_busy", 64'(busy_now), 64'd0);
      check("tx_en_width", 64'(prev_tx_en), 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got byte %0h expected none", tx_data);
      end else begin
        check("tx_byte", 64'(tx_data), 64'(sb.pop_front()));
      end
      busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    model_busy = (busy_cnt != 0);
    prev_tx_en = tx_en;
  end

  task automatic send(input logic [63:0] d);
    @(negedge sys_clk);
    pkt_data = d;
    pkt_en   = 1'b1;
    @(negedge sys_clk);
    pkt_en   = 1'b0;
  endtask

  task automatic pend_model(input logic [63:0] d);
    if (exp_pend && (exp_drop != 16'hFFFF)) exp_drop = exp_drop + 16'd1;
    exp_pend      = 1'b1;
    exp_pend_data = d;
  endtask

  task automatic send_pend(input logic [63:0] d);
    pend_model(d);
    send(d);
  endtask

  task automatic commit_pend();
    push_frame(exp_pend_data);
    exp_pend = 1'b0;
  endtask

  task automatic flood(input int k, input logic [63:0] d);
    @(negedge sys_clk);
    pkt_data = d;
    pkt_en   = 1'b1;
    for (int i = 0; i < k; i++) pend_model(d);
    repeat (k) @(negedge sys_clk);
    pkt_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < WAIT_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    if (!frame_done) check({tag, "_timeout"}, 64'(frame_done), 64'd1);
  endtask

  initial begin
    int d0;
    int base;
    int n;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", 64'(tx_en), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_frame_busy", 64'(frame_busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Basic frame and issue latency
    d0 = done_seen;
    push_frame(64'h0000_0064_0000_00C8);
    send(64'h0000_0064_0000_00C8);
    @(negedge sys_clk);
    check("t1_latency", 64'(tx_en), 64'd1);
    check("t1_frame_busy", 64'(frame_busy), 64'd1);
    wait_done("t1");
    @(negedge sys_clk);
    check("t1_done_pulse", 64'(frame_done), 64'd0);
    check("t1_done_cnt", 64'(done_seen - d0), 64'd1);
    check("t1_drop", 64'(drop_cnt), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Transmitter busy when packet arrives
    hold_busy = 1'b1;
    push_frame(64'h0123_4567_89AB_CDEF);
    send(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      check("t2_no_tx_en", 64'(tx_en), 64'd0);
    end
    hold_busy = 1'b0;
    n = 0;
    while (!tx_en && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("t2_tx_en_seen", 64'(tx_en), 64'd1);
    @(negedge sys_clk);
    check("t2_tx_en_one_cycle", 64'(tx_en), 64'd0);
    wait_done("t2");
    @(negedge sys_clk);

    // pkt_en coincident with DONE, pending empty
    push_frame(64'h1111_2222_3333_4444);
    send(64'h1111_2222_3333_4444);
    wait_done("t4a");
    check("t4_busy_low_in_done", 64'(frame_busy), 64'd0);
    push_frame(64'hDEAD_BEEF_0BAD_F00D);
    pkt_data = 64'hDEAD_BEEF_0BAD_F00D;
    pkt_en   = 1'b1;
    @(negedge sys_clk);
    pkt_en = 1'b0;
    check("t4_busy_restart", 64'(frame_busy), 64'd1);
    check("t4_done_cleared", 64'(frame_done), 64'd0);
    @(negedge sys_clk);
    check("t4_no_idle_gap", 64'(tx_en), 64'd1);
    wait_done("t4b");
    @(negedge sys_clk);

    // Checksum wrap-around
    push_frame(64'hFFFF_FFFF_FFFF_FFFF);
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("t6");
    @(negedge sys_clk);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Three packets in one frame: middle one dropped
    push_frame(64'hA1A1_A1A1_0000_0001);
    send(64'hA1A1_A1A1_0000_0001);
    send_pend(64'hB2B2_B2B2_0000_0002);
    send_pend(64'hC3C3_C3C3_0000_0003);
    commit_pend();
    wait_done("t3a");
    @(negedge sys_clk);
    wait_done("t3b");
    @(negedge sys_clk);
    check("t3_drop_one", 64'(drop_cnt), 64'(exp_drop));
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Saturate drop counter while the transmitter is held busy
    hold_busy = 1'b1;
    push_frame(64'h5A5A_0000_0000_A5A5);
    send(64'h5A5A_0000_0000_A5A5);
    flood(32'hFFFE - int'(exp_drop) + 1, 64'h0F0F_1E1E_2D2D_3C3C);
    check("t3_drop_fffe", 64'(drop_cnt), 64'(exp_drop));
    flood(1, 64'h0F0F_1E1E_2D2D_3C3C);
    check("t3_drop_ffff", 64'(drop_cnt), 64'(exp_drop));
    flood(3, 64'h0F0F_1E1E_2D2D_3C3C);
    check("t3_drop_no_wrap", 64'(drop_cnt), 64'hFFFF);
    commit_pend();
    hold_busy = 1'b0;
    wait_done("t3c");
    @(negedge sys_clk);
    wait_done("t3d");
    @(negedge sys_clk);
    check("t3_sat_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-frame during payload byte 5
    base = bytes_seen;
    push_frame(64'h7766_5544_3322_1100);
    send(64'h7766_5544_3322_1100);
    n = 0;
    while (bytes_seen < base + 8 && n < WAIT_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    check("t5_reached_byte", 64'(bytes_seen >= base + 8), 64'd1);
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    sb.delete();
    exp_drop = '0;
    exp_pend = 1'b0;
    @(negedge sys_clk);
    check("t5_tx_en", 64'(tx_en), 64'd0);
    check("t5_frame_busy", 64'(frame_busy), 64'd0);
    check("t5_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    d0 = done_seen;
    push_frame(64'hCAFE_BABE_1234_5678);
    send(64'hCAFE_BABE_1234_5678);
    wait_done("t5");
    @(negedge sys_clk);
    check("t5_done_cnt", 64'(done_seen - d0), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
